piccolo80_dec: RTL and testbench

Iterative Piccolo-80 decryption core. It takes a 64-bit ciphertext and an 80-bit key through a start/done handshake and returns the 64-bit plaintext after 25 rounds. It is the inverse-direction companion of the Piccolo-80 encryption datapath in the Piccolo80 tree, and it shares that core's byte ordering, S-box, F-function and round permutation.

---
 rtl/piccolo80_dec.sv | 214 +++++++++++++++++++++
 tb/tb_piccolo80_dec.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piccolo80_dec.sv
// piccolo80_dec: iterative Piccolo-80 block decryption core.
// A 64-bit ciphertext and an 80-bit key are taken on an accepted start while
// ready is high; after 25 decryption rounds the plaintext is registered and
// done pulses for one cycle. Round keys are derived on the fly from the
// latched key and the round counter, walking the encryption schedule backwards.
// Build option: define PICCOLO_DEC_UNROLL4_EN to execute four rounds per cycle
// (six 4-round cycles plus one final single round); default is one round per cycle.
module piccolo80_dec #(
    parameter int ROUNDS = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:63] ciphertext,
    input  logic [0:79] key,
    output logic        ready,
    output logic        done,
    output logic [0:63] plaintext
);

    localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

`ifdef PICCOLO_DEC_UNROLL4_EN
    localparam logic [4:0] RND_STEP = 5'd4;
`else
    localparam logic [4:0] RND_STEP = 5'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      fsm_q,   fsm_d;
    logic [4:0]  rnd_q,   rnd_d;
    logic [79:0] key_q,   key_d;
    logic [63:0] blk_q,   blk_d;
    logic [63:0] pt_q,    pt_d;
    logic        done_q,  done_d;
    logic        ready_q, ready_d;

    logic [79:0] key_in;
    logic [63:0] ct_in;
    logic [63:0] step_blk;
    logic [63:0] last_blk;

    assign key_in = key;
    assign ct_in  = ciphertext;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'he;  4'h1: y = 4'h4;  4'h2: y = 4'hb;  4'h3: y = 4'h2;
            4'h4: y = 4'h3;  4'h5: y = 4'h8;  4'h6: y = 4'h0;  4'h7: y = 4'h9;
            4'h8: y = 4'h1;  4'h9: y = 4'ha;  4'ha: y = 4'h7;  4'hb: y = 4'hf;
            4'hc: y = 4'h6;  4'hd: y = 4'hc;  4'he: y = 4'h5;  default: y = 4'hd;
        endcase
        return y;
    endfunction

    // Multiply by x in GF(2^4) with modulus x^4+x+1.
    function automatic logic [3:0] xt(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    // S layer, circulant MixColumn (2,3,1,1), S layer.
    function automatic logic [15:0] f_fn(input logic [15:0] x);
        logic [3:0] a0, a1, a2, a3;
        logic [3:0] b0, b1, b2, b3;
        a0 = sbox(x[15:12]);
        a1 = sbox(x[11:8]);
        a2 = sbox(x[7:4]);
        a3 = sbox(x[3:0]);
        b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {sbox(b0), sbox(b1), sbox(b2), sbox(b3)};
    endfunction

    // Byte permutation (x0..x7) -> (x2,x7,x4,x1,x6,x3,x0,x5), x0 = most significant byte.
    function automatic logic [63:0] rperm(input logic [63:0] s);
        return {s[47:40], s[7:0], s[31:24], s[55:48],
                s[15:8], s[39:32], s[63:56], s[23:16]};
    endfunction

    // Encryption round-key pair {rk2j, rk2j+1} for encryption round j.
    function automatic logic [31:0] enc_rk(input logic [79:0] k, input logic [4:0] j);
        logic [4:0]  c;
        logic [31:0] con;
        logic [31:0] kp;
        c   = j + 5'd1;
        con = {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ 32'h0F1E2D3C;
        case (j % 5'd5)
            5'd1, 5'd4: kp = k[79:48];
            5'd3:       kp = {k[15:0], k[15:0]};
            default:    kp = k[47:16];
        endcase
        return con ^ kp;
    endfunction

    // One decryption round r; encryption round 24-r supplies the keys, swapped on odd r.
    function automatic logic [63:0] dec_round(input logic [63:0] s, input logic [79:0] k,
                                              input logic [4:0] r);
        logic [31:0] pair;
        logic [15:0] rk0, rk1;
        logic [15:0] x1, x3;
        logic [63:0] t;
        pair = enc_rk(k, LAST_RND - r);
        rk0  = r[0] ? pair[15:0]  : pair[31:16];
        rk1  = r[0] ? pair[31:16] : pair[15:0];
        x1   = s[47:32] ^ f_fn(s[63:48]) ^ rk0;
        x3   = s[15:0]  ^ f_fn(s[31:16]) ^ rk1;
        t    = {s[63:48], x1, s[31:16], x3};
        return (r == LAST_RND) ? t : rperm(t);
    endfunction

    // Input whitening mask: X0 ^= wk2, X2 ^= wk3.
    function automatic logic [63:0] in_white(input logic [79:0] k);
        return {k[15:8], k[23:16], 16'h0, k[31:24], k[7:0], 16'h0};
    endfunction

    // Output whitening mask: X0 ^= wk0, X2 ^= wk1.
    function automatic logic [63:0] out_white(input logic [79:0] k);
        return {k[79:72], k[55:48], 16'h0, k[63:56], k[71:64], 16'h0};
    endfunction

`ifdef PICCOLO_DEC_UNROLL4_EN
    // Four consecutive permuting rounds starting at rnd_q (only used while rnd_q < 24).
    always_comb begin
        step_blk = dec_round(dec_round(dec_round(dec_round(blk_q, key_q, rnd_q),
                                                 key_q, rnd_q + 5'd1),
                                       key_q, rnd_q + 5'd2),
                             key_q, rnd_q + 5'd3);
    end
`else
    // Single permuting round at rnd_q.
    always_comb begin
        step_blk = dec_round(blk_q, key_q, rnd_q);
    end
`endif

    // Final round plus output whitening, producing the plaintext.
    always_comb begin
        last_blk = dec_round(blk_q, key_q, LAST_RND) ^ out_white(key_q);
    end

    // Next-state logic for the IDLE/RUN/DONE controller and datapath registers.
    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        blk_d   = blk_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    blk_d   = ct_in ^ in_white(key_in);
                    rnd_d   = 5'd0;
                    ready_d = 1'b0;
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (rnd_q == LAST_RND) begin
                    pt_d   = last_blk;
                    done_d = 1'b1;
                    fsm_d  = S_DONE;
                end else begin
                    blk_d = step_blk;
                    rnd_d = rnd_q + RND_STEP;
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                fsm_d   = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                fsm_d   = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= S_IDLE;
            rnd_q   <= 5'd0;
            key_q   <= 80'h0;
            blk_q   <= 64'h0;
            pt_q    <= 64'h0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
            blk_q   <= blk_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign plaintext = pt_q;

endmodule

// File: tb/tb_piccolo80_dec.sv
// Testbench for piccolo80_dec: known answer, random round trips through a
// behavioural Piccolo-80 encryption model, busy-ignore, reset abort and hold.
module tb_piccolo80_dec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] ciphertext;
    logic [79:0] key;
    logic        ready;
    logic        done;
    logic [63:0] plaintext;

    piccolo80_dec dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .ready      (ready),
        .done       (done),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;

`ifdef PICCOLO_DEC_UNROLL4_EN
    localparam int LAT    = 8;
    localparam int RST_AT = 3;
`else
    localparam int LAT    = 26;
    localparam int RST_AT = 11;
`endif
    localparam int PERIOD = LAT + 1;

    localparam logic [79:0] KAT_KEY = 80'h00112233445566778899;
    localparam logic [63:0] KAT_CT  = 64'h8D2BFF9935F84056;
    localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural reference model ----------------
    localparam logic [63:0] SBOX = 64'hE4B238091A7F6C5D;
    localparam logic [63:0] MC   = 64'h2311123111233112;
    int ka [5] = '{2, 0, 2, 4, 0};
    int kb [5] = '{3, 1, 3, 4, 1};
    int pm [8] = '{2, 7, 4, 1, 6, 3, 0, 5};

    function automatic logic [3:0] m_s(input logic [3:0] x);
        return SBOX[60 - 4 * int'(x) +: 4];
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] aa;
        logic [3:0] p;
        aa = {1'b0, a};
        p  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa[3:0];
            aa = aa << 1;
            if (aa[4]) aa = aa ^ 5'h13;
        end
        return p;
    endfunction

    function automatic logic [15:0] m_f(input logic [15:0] x);
        logic [3:0]  s [4];
        logic [3:0]  y;
        logic [15:0] r;
        r = 16'h0;
        for (int c = 0; c < 4; c++) s[c] = m_s(x[15 - 4 * c -: 4]);
        for (int row = 0; row < 4; row++) begin
            y = 4'h0;
            for (int c = 0; c < 4; c++) y = y ^ gf_mul(MC[60 - 16 * row - 4 * c +: 4], s[c]);
            r[15 - 4 * row -: 4] = m_s(y);
        end
        return r;
    endfunction

    function automatic logic [15:0] m_k(input logic [79:0] k, input int m);
        return k[79 - 16 * m -: 16];
    endfunction

    function automatic logic [15:0] m_wk(input logic [79:0] k, input int n);
        logic [15:0] a, b;
        case (n)
            0: begin a = m_k(k, 0); b = m_k(k, 1); end
            1: begin a = m_k(k, 1); b = m_k(k, 0); end
            2: begin a = m_k(k, 4); b = m_k(k, 3); end
            default: begin a = m_k(k, 3); b = m_k(k, 4); end
        endcase
        return {a[15:8], b[7:0]};
    endfunction

    // Encryption round key number idx (0..49).
    function automatic logic [15:0] m_rk(input logic [79:0] k, input int idx);
        int          i;
        logic [31:0] c, con;
        i   = idx / 2;
        c   = 32'(i + 1);
        con = ((c << 27) | (c << 17) | (c << 10) | c) ^ 32'h0F1E2D3C;
        if (idx % 2 == 0) return con[31:16] ^ m_k(k, ka[i % 5]);
        else              return con[15:0]  ^ m_k(k, kb[i % 5]);
    endfunction

    function automatic logic [63:0] m_rp(input logic [63:0] s, input bit inverse);
        logic [63:0] y;
        y = 64'h0;
        for (int j = 0; j < 8; j++) begin
            if (inverse) y[63 - 8 * pm[j] -: 8] = s[63 - 8 * j -: 8];
            else         y[63 - 8 * j -: 8]     = s[63 - 8 * pm[j] -: 8];
        end
        return y;
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] p, input logic [79:0] k);
        logic [63:0] s;
        s = p ^ {m_wk(k, 0), 16'h0, m_wk(k, 1), 16'h0};
        for (int i = 0; i < 25; i++) begin
            s[47:32] = s[47:32] ^ m_f(s[63:48]) ^ m_rk(k, 2 * i);
            s[15:0]  = s[15:0]  ^ m_f(s[31:16]) ^ m_rk(k, 2 * i + 1);
            if (i < 24) s = m_rp(s, 1'b0);
        end
        return s ^ {m_wk(k, 2), 16'h0, m_wk(k, 3), 16'h0};
    endfunction

    // Decryption as the literal inverse of m_enc, unwinding rounds 24..0.
    function automatic logic [63:0] m_dec(input logic [63:0] c, input logic [79:0] k);
        logic [63:0] s;
        s = c ^ {m_wk(k, 2), 16'h0, m_wk(k, 3), 16'h0};
        for (int i = 24; i >= 0; i--) begin
            if (i < 24) s = m_rp(s, 1'b1);
            s[47:32] = s[47:32] ^ m_f(s[63:48]) ^ m_rk(k, 2 * i);
            s[15:0]  = s[15:0]  ^ m_f(s[31:16]) ^ m_rk(k, 2 * i + 1);
        end
        return s ^ {m_wk(k, 0), 16'h0, m_wk(k, 1), 16'h0};
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [79:0] r80();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[79:0];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 64'(ready), 64'h1);
    endtask

    // One transaction; inputs are scrambled right after acceptance.
    task automatic run_block(input logic [63:0] c, input logic [79:0] k, input string tag,
                             input logic [63:0] exp);
        int lat;
        wait_ready();
        start      = 1'b1;
        ciphertext = c;
        key        = k;
        @(negedge clk);
        start      = 1'b0;
        ciphertext = r64();
        key        = r80();
        lat        = 1;
        while (done !== 1'b1 && lat < LAT + 60) begin
            @(negedge clk);
            lat++;
            if (lat == 2) chk({tag, "_busy"}, 64'(ready), 64'h0);
        end
        chk({tag, "_pt"}, plaintext, exp);
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    endtask

    initial begin
        logic [63:0] p, c, c2, p1, p2;
        logic [79:0] k, k2;
        int          cnt, dn, t1, t2;
        bit          c2_set;

        reset      = 1'b1;
        start      = 1'b0;
        ciphertext = 64'h0;
        key        = 80'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'h1);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_pt", plaintext, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Known answer, then hold/stability.
        run_block(KAT_CT, KAT_KEY, "kat", KAT_PT);
        dn = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("hold_pt", plaintext, KAT_PT);
        chk("hold_done", 64'(dn), 64'h0);

        // All-zero and all-one key/block.
        run_block(m_enc(64'h0, 80'h0), 80'h0, "zero", 64'h0);
        run_block(m_enc({64{1'b1}}, {80{1'b1}}), {80{1'b1}}, "ones", {64{1'b1}});

        // Random round trips.
        for (int i = 0; i < 16; i++) begin
            p = r64();
            k = r80();
            run_block(m_enc(p, k), k, $sformatf("rt%0d", i), p);
        end

        // Random ciphertexts against the inverse model.
        for (int i = 0; i < 4; i++) begin
            c = r64();
            k = r80();
            run_block(c, k, $sformatf("rc%0d", i), m_dec(c, k));
        end

        // Busy ignore with start held high and inputs churning.
        wait_ready();
        p1 = r64();  k = r80();
        p2 = r64();  k2 = r80();
        c  = m_enc(p1, k);
        c2 = m_enc(p2, k2);
        start = 1'b1; ciphertext = c; key = k;
        cnt = 0; dn = 0; t1 = 0; t2 = 0; c2_set = 1'b0;
        while (dn < 2 && cnt < 2 * PERIOD + 40) begin
            @(negedge clk);
            cnt++;
            if (done === 1'b1) begin
                dn++;
                if (dn == 1) begin
                    t1 = cnt;
                    chk("busy_first_pt", plaintext, p1);
                end else begin
                    t2 = cnt;
                    chk("busy_second_pt", plaintext, p2);
                end
            end
            if (dn == 1 && !c2_set && cnt == t1 + 1) begin
                chk("busy_ready_again", 64'(ready), 64'h1);
                ciphertext = c2;
                key        = k2;
                c2_set     = 1'b1;
            end else begin
                ciphertext = r64();
                key        = r80();
            end
        end
        start = 1'b0;
        chk("busy_first_lat", 64'(t1), 64'(LAT));
        chk("busy_period", 64'(t2 - t1), 64'(PERIOD));
        chk("busy_done_count", 64'(dn), 64'h2);

        // Reset in the middle of a run.
        wait_ready();
        start = 1'b1; ciphertext = r64(); key = r80();
        @(negedge clk);
        start = 1'b0;
        repeat (RST_AT) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", 64'(ready), 64'h1);
        chk("midrst_pt", plaintext, 64'h0);
        chk("midrst_done", 64'(done), 64'h0);
        dn = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        chk("midrst_no_done", 64'(dn), 64'h0);
        run_block(KAT_CT, KAT_KEY, "kat2", KAT_PT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
